// File: rtl/fetch_decode_pkg.sv
// Shared definitions for the fetch/decode sequencer: ALU operation codes,
// control opcodes, sequencer states and small decode helpers.
package fetch_decode_pkg;

  typedef enum logic [3:0] {
    doNothing         = 4'd0,
    absDiff           = 4'd1,
    aluLSR1           = 4'd2,
    oneLSL            = 4'd3,
    oneLSLMinus1      = 4'd4,
    strMatch          = 4'd5,
    addu              = 4'd6,
    aluIncrementIfSet = 4'd7,
    setNegative       = 4'd8,
    LSL1              = 4'd9,
    min               = 4'd10,
    decrementSetZero  = 4'd11,
    decrementSetOne   = 4'd12,
    adduTwo           = 4'd13
  } alu_op_t;

  localparam logic [3:0] BRF  = 4'd14;
  localparam logic [3:0] HALT = 4'd15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic is_alu_op(input logic [3:0] op);
    return op < BRF;
  endfunction

  // strMatch and setNegative only produce a flag; their result is discarded
  function automatic logic writes_reg(input logic [3:0] op);
    return is_alu_op(op) && (op != 4'(strMatch)) && (op != 4'(setNegative));
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/fetch_decode.sv
// Two-cycle fetch/execute sequencer: fetches a 9-bit instruction from ROM,
// drives ALU/register-file controls, handles flag branches and halt.
module fetch_decode
  import fetch_decode_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [8:0] instr,
  input  logic       aluFlag,
  output logic [7:0] pc,
  output alu_op_t    aluOp,
  output logic [2:0] rdAddr,
  output logic [1:0] rsAddr,
  output logic       regWrEn,
  output logic       flagOut,
  output logic       done,
  output logic [15:0] cycleCount
);

  state_t      state, state_next;
  logic [8:0]  ir;
  logic        flag;
  logic [3:0]  op;
  logic [7:0]  br_offset;

  assign op        = ir[8:5];
  assign br_offset = {{3{ir[4]}}, ir[4:0]};
  assign flagOut   = flag;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (start) state_next = FETCH;
      FETCH:      state_next = EXEC;
      EXEC:       state_next = (op == HALT) ? DONE : FETCH;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc         <= '0;
      ir         <= '0;
      flag       <= 1'b0;
      cycleCount <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            pc         <= '0;
            flag       <= 1'b0;
            cycleCount <= '0;
          end
        end
        FETCH: begin
          ir         <= instr;
          cycleCount <= sat_inc16(cycleCount);
        end
        EXEC: begin
          cycleCount <= sat_inc16(cycleCount);
          if (is_alu_op(op)) begin
            flag <= aluFlag;
            pc   <= pc + 8'd1;
          end else if (op == BRF) begin
            pc <= flag ? pc + br_offset : pc + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Write enable is gated by reset so a reset landing mid-EXEC never
  // commits a register write on that same edge.
  always_comb begin
    aluOp   = doNothing;
    rdAddr  = '0;
    rsAddr  = '0;
    regWrEn = 1'b0;
    done    = (state == DONE);
    if (state == EXEC && is_alu_op(op)) begin
      aluOp   = alu_op_t'(op);
      rdAddr  = ir[4:2];
      rsAddr  = ir[1:0];
      regWrEn = writes_reg(op) && !reset;
    end
  end

endmodule

// File: tb/tb_fetch_decode.sv
// Directed bench for fetch_decode: a behavioural ROM array feeds instr and
// each scenario checks hand-derived control outputs cycle by cycle.
module tb_fetch_decode;
  import fetch_decode_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [8:0]  instr;
  logic        aluFlag;
  logic [7:0]  pc;
  alu_op_t     aluOp;
  logic [2:0]  rdAddr;
  logic [1:0]  rsAddr;
  logic        regWrEn;
  logic        flagOut;
  logic        done;
  logic [15:0] cycleCount;

  logic [8:0]  rom [0:255];
  int unsigned errors = 0;
  int unsigned checks = 0;

  fetch_decode dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .instr      (instr),
    .aluFlag    (aluFlag),
    .pc         (pc),
    .aluOp      (aluOp),
    .rdAddr     (rdAddr),
    .rsAddr     (rsAddr),
    .regWrEn    (regWrEn),
    .flagOut    (flagOut),
    .done       (done),
    .cycleCount (cycleCount)
  );

  assign instr = rom[pc];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n = 1);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_rom();
    for (int unsigned i = 0; i < 256; i++) rom[i] = 9'h000;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    reset   = 1'b0;
    start   = 1'b0;
    aluFlag = 1'b0;
    clear_rom();

    // HALT at address 0
    rom[0] = 9'h1E0;
    do_reset();
    check("rst_pc", pc, 0);
    check("rst_done", done, 0);
    check("rst_cc", cycleCount, 0);
    check("rst_wr", regWrEn, 0);
    check("rst_op", aluOp, 0);
    check("rst_flag", flagOut, 0);
    tick(3);
    check("idle_hold_cc", cycleCount, 0);
    pulse_start();
    check("halt_fetch_done", done, 0);
    tick();
    check("halt_exec_done", done, 0);
    check("halt_exec_op", aluOp, 0);
    tick();
    check("halt_done", done, 1);
    check("halt_pc", pc, 0);
    check("halt_cc", cycleCount, 2);
    tick(3);
    check("halt_done_hold", done, 1);
    check("halt_cc_hold", cycleCount, 2);

    // addu rd=3 rs=1 with aluFlag=1
    clear_rom();
    rom[0] = 9'h0CD;
    rom[1] = 9'h1E0;
    aluFlag = 1'b1;
    do_reset();
    pulse_start();
    check("addu_fetch_wr", regWrEn, 0);
    tick();
    check("addu_exec_wr", regWrEn, 1);
    check("addu_rd", rdAddr, 3);
    check("addu_rs", rsAddr, 1);
    check("addu_op", aluOp, 6);
    tick();
    check("addu_after_wr", regWrEn, 0);
    check("addu_flag", flagOut, 1);
    check("addu_pc", pc, 1);
    tick();
    check("halt_exec_wr", regWrEn, 0);
    check("halt_exec_rd", rdAddr, 0);
    tick();
    check("addu_halt_done", done, 1);
    check("addu_halt_pc", pc, 1);

    // BRF -3 at pc 5, taken (flag=1) and not taken (flag=0)
    for (int unsigned f = 0; f < 2; f++) begin
      clear_rom();
      rom[5] = 9'h1DD;
      aluFlag = (f == 0);
      do_reset();
      pulse_start();
      tick(10);
      check("brf_at5", pc, 5);
      check("brf_flag_in", flagOut, (f == 0));
      tick();
      check("brf_exec_op", aluOp, 0);
      check("brf_exec_rd", rdAddr, 0);
      check("brf_exec_wr", regWrEn, 0);
      aluFlag = ~aluFlag;
      tick();
      check("brf_pc", pc, (f == 0) ? 2 : 6);
      check("brf_flag_kept", flagOut, (f == 0));
    end

    // strMatch writes flag only
    clear_rom();
    rom[0] = 9'h0A0;
    aluFlag = 1'b1;
    do_reset();
    pulse_start();
    tick();
    check("strm_op", aluOp, 5);
    check("strm_wr", regWrEn, 0);
    tick();
    check("strm_flag", flagOut, 1);
    check("strm_pc", pc, 1);

    // setNegative (op 8) also suppresses the write
    clear_rom();
    rom[0] = 9'h11F;
    aluFlag = 1'b0;
    do_reset();
    pulse_start();
    tick();
    check("setn_op", aluOp, 8);
    check("setn_rd", rdAddr, 7);
    check("setn_wr", regWrEn, 0);

    // pc wrap 255 -> 0
    clear_rom();
    rom[255] = 9'h0CD;
    do_reset();
    pulse_start();
    tick(510);
    check("wrap_at255", pc, 255);
    tick();
    check("wrap_exec_op", aluOp, 6);
    tick();
    check("wrap_pc", pc, 0);
    check("wrap_done", done, 0);

    // reset landing mid-EXEC
    clear_rom();
    rom[0] = 9'h0CD;
    aluFlag = 1'b1;
    do_reset();
    pulse_start();
    tick();
    check("rexec_wr_before", regWrEn, 1);
    reset = 1'b1;
    #1;
    check("rexec_wr_gated", regWrEn, 0);
    tick();
    reset = 1'b0;
    check("rexec_wr", regWrEn, 0);
    check("rexec_op", aluOp, 0);
    check("rexec_pc", pc, 0);
    check("rexec_flag", flagOut, 0);
    check("rexec_cc", cycleCount, 0);
    check("rexec_done", done, 0);
    tick(2);
    check("rexec_idle_cc", cycleCount, 0);

    // start ignored during EXEC; start from DONE restarts
    clear_rom();
    rom[0] = 9'h0CD;
    rom[1] = 9'h1E0;
    do_reset();
    pulse_start();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ign_pc", pc, 1);
    check("ign_cc", cycleCount, 2);
    tick(2);
    check("ign_done", done, 1);
    check("ign_done_cc", cycleCount, 4);
    pulse_start();
    check("restart_pc", pc, 0);
    check("restart_cc", cycleCount, 0);
    check("restart_done", done, 0);
    check("restart_flag", flagOut, 0);
    tick();
    check("restart_exec_op", aluOp, 6);

    // cycleCount saturation over a long doNothing stream
    clear_rom();
    aluFlag = 1'b0;
    do_reset();
    pulse_start();
    for (int unsigned n = 0; n < 70000 && cycleCount != 16'hFFFF; n++) tick();
    check("sat_reached", cycleCount, 16'hFFFF);
    tick(3);
    check("sat_hold", cycleCount, 16'hFFFF);
    check("sat_running", done, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_decode.md
FETCH_DECODE -- requirements
Module: fetch_decode

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: begins program execution from pc 0; honoured only in IDLE or DONE.
REQ-004 SHALL have port instr, input, 9 bits: instruction word from combinational instruction ROM addressed by pc.
REQ-005 SHALL have port aluFlag, input, 1 bit: flag output of the ALU for the currently driven operation.
REQ-006 SHALL have port pc, output, 8 bits: instruction ROM address.
REQ-007 SHALL have port aluOp, output, 4 bits: ALU operation code, typed with the shared operation enum.
REQ-008 SHALL have ports rdAddr (3 bits) and rsAddr (2 bits), outputs: register-file addresses for ALU operands A and B.
REQ-009 SHALL have port regWrEn, output, 1 bit: write ALU out into register rdAddr at the next clk edge.
REQ-010 SHALL have port flagOut, output, 1 bit: flag register value, drives the ALU flagIn.
REQ-011 SHALL have ports done (1 bit) and cycleCount (16 bits), outputs: program halted; cycles spent since start.

Function
REQ-012 SHALL implement states IDLE, FETCH, EXEC, DONE.
REQ-013 SHALL go IDLE->FETCH or DONE->FETCH on start=1, setting pc=0, cycleCount=0, flag=0.
REQ-014 SHALL, in FETCH, latch instr into an internal 9-bit instruction register (IR) and go to EXEC; each instruction takes exactly 2 cycles.
REQ-015 SHALL decode IR: op=IR[8:5]; op 0-13 = ALU op (aluOp=op), 14 = BRF, 15 = HALT.
REQ-016 SHALL, for ALU ops, drive rdAddr=IR[4:2], rsAddr=IR[1:0] during EXEC.
REQ-017 SHALL assert regWrEn only in EXEC for ALU ops other than strMatch (5) and setNegative (8); 0 in all other states and ops.
REQ-018 SHALL load flag from aluFlag at the end of EXEC for every ALU op; BRF and HALT leave flag unchanged.
REQ-019 SHALL, at end of EXEC, set pc=pc+1 (mod 256) for ALU ops and for BRF with flag=0.
REQ-020 SHALL, for BRF with flag=1, set pc=pc+signext(IR[4:0]) mod 256 (range -16..+15).
REQ-021 SHALL, on HALT in EXEC, go to DONE with pc unchanged and done=1; done remains 1 until start or reset.
REQ-022 SHALL drive aluOp=doNothing (0) and rd/rs addresses 0 outside EXEC and for BRF/HALT.
REQ-023 SHALL increment cycleCount every cycle in FETCH and EXEC, saturating at 16'hFFFF; hold in IDLE and DONE.
REQ-024 SHALL ignore start while in FETCH or EXEC.
REQ-025 SHALL treat pc wrap 255->0 as normal sequencing (no halt, no error).

Reset
REQ-026 SHALL, on reset=1 at a clk edge, enter IDLE with pc=0, IR=0, flag=0, done=0, cycleCount=0, regWrEn=0, aluOp=0; reset overrides start and any state, including mid-EXEC (no register write).

Structure
REQ-027 SHALL take the ALU operation enum from the shared definitions package: doNothing=0, absDiff=1, aluLSR1=2, oneLSL=3, oneLSLMinus1=4, strMatch=5, addu=6, aluIncrementIfSet=7, setNegative=8, LSL1=9, min=10, decrementSetZero=11, decrementSetOne=12, adduTwo=13.
REQ-028 SHALL add to that package the opcode constants BRF=14 and HALT=15 and the state enum.
REQ-029 SHALL be a single module with no sub-modules; the ALU and register file are instantiated by the parent.

Verification
REQ-030 Reset then start pulse, ROM[0]=9'h1E0 (HALT) -> FETCH, EXEC, DONE; done=1 on cycle 3; pc=0; cycleCount=2.
REQ-031 ROM[0]=addu rd=3 rs=1 (9'h0CD), aluFlag=1 -> regWrEn=1 only in EXEC, rdAddr=3, rsAddr=1, aluOp=6; afterwards flagOut=1, pc=1.
REQ-032 flag=1, ROM[5]=BRF offset -3 (9'h1DD) -> pc=2 after EXEC; same with flag=0 -> pc=6.
REQ-033 strMatch (9'h0A0) with aluFlag=1 -> regWrEn=0, flagOut=1.
REQ-034 pc=255 executing an ALU op -> pc=0 next; reset asserted during EXEC -> IDLE, regWrEn=0 in the following cycle, all outputs at reset values.
REQ-035 start pulsed during EXEC -> ignored; start in DONE -> pc=0, cycleCount=0, done=0, FETCH.
